// File: rtl/jt12_dac_sd1.sv
// jt12_dac_sd1: first-order sigma-delta 1-bit DAC, carry of acc+target is the output bit
module jt12_dac_sd1 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] target,
  output logic         bit_out
);
  logic [W-1:0] acc_q, acc_d;
  logic         bit_q, bit_d;
  logic [W:0]   sum;
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, target};
    acc_d = cen ? sum[W-1:0] : acc_q;
    bit_d = cen ? sum[W] : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      bit_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bit_q <= bit_d;
    end
  end
  assign bit_out = bit_q;
endmodule

// File: rtl/jt12_dac_out.sv
// jt12_dac_out: captures FIR L/R samples, rounds/saturates to DAC_W-bit PCM and drives two sigma-delta streams
module jt12_dac_out #(
  parameter int IN_W  = 20,
  parameter int SHIFT = 4,
  parameter int DAC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_in,
  input  logic signed [IN_W-1:0]  left_in,
  input  logic signed [IN_W-1:0]  right_in,
  input  logic                    cen,
  input  logic                    sat_clr,
  output logic signed [DAC_W-1:0] left_pcm,
  output logic signed [DAC_W-1:0] right_pcm,
  output logic                    pcm_valid,
  output logic                    left_bit,
  output logic                    right_bit,
  output logic                    sat_l,
  output logic                    sat_r
);
  function automatic logic signed [IN_W:0] rnd(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] e, h;
    e = {x[IN_W-1], x};
    h = (IN_W+1)'(1) << (SHIFT-1);
    return (e + h) >>> SHIFT;
  endfunction
  function automatic logic ovf(input logic signed [IN_W:0] r);
    return !((&r[IN_W:DAC_W-1]) || !(|r[IN_W:DAC_W-1]));
  endfunction
  function automatic logic [DAC_W-1:0] sat(input logic signed [IN_W:0] r);
    return ovf(r) ? {r[IN_W], {(DAC_W-1){~r[IN_W]}}} : r[DAC_W-1:0];
  endfunction
  logic                   last_q, last_d, edge_s;
  logic [IN_W-1:0]        xl_q, xl_d, xr_q, xr_d;
  logic signed [IN_W:0]   rl_q, rl_d, rr_q, rr_d;
  logic [DAC_W-1:0]       pl_q, pl_d, pr_q, pr_d, tl_q, tl_d, tr_q, tr_d, sl, sr;
  logic                   v0_q, v0_d, v1_q, v1_d, pv_q, pv_d, sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  always_comb begin
    last_d  = sample_in;
    edge_s  = sample_in & ~last_q;
    v0_d    = edge_s;
    xl_d    = edge_s ? left_in : xl_q;
    xr_d    = edge_s ? right_in : xr_q;
    v1_d    = v0_q;
    rl_d    = v0_q ? rnd(xl_q) : rl_q;
    rr_d    = v0_q ? rnd(xr_q) : rr_q;
    sl      = sat(rl_q);
    sr      = sat(rr_q);
    pv_d    = v1_q;
    pl_d    = v1_q ? sl : pl_q;
    pr_d    = v1_q ? sr : pr_q;
    tl_d    = v1_q ? {~sl[DAC_W-1], sl[DAC_W-2:0]} : tl_q;
    tr_d    = v1_q ? {~sr[DAC_W-1], sr[DAC_W-2:0]} : tr_q;
    sat_l_d = (v1_q && ovf(rl_q)) ? 1'b1 : sat_clr ? 1'b0 : sat_l_q;
    sat_r_d = (v1_q && ovf(rr_q)) ? 1'b1 : sat_clr ? 1'b0 : sat_r_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b0;
      xl_q    <= '0;
      xr_q    <= '0;
      v0_q    <= 1'b0;
      rl_q    <= '0;
      rr_q    <= '0;
      v1_q    <= 1'b0;
      pl_q    <= '0;
      pr_q    <= '0;
      pv_q    <= 1'b0;
      tl_q    <= {1'b1, {(DAC_W-1){1'b0}}};
      tr_q    <= {1'b1, {(DAC_W-1){1'b0}}};
      sat_l_q <= 1'b0;
      sat_r_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      v0_q    <= v0_d;
      rl_q    <= rl_d;
      rr_q    <= rr_d;
      v1_q    <= v1_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      pv_q    <= pv_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
      sat_l_q <= sat_l_d;
      sat_r_q <= sat_r_d;
    end
  end
  jt12_dac_sd1 #(.W(DAC_W)) u_sd_l (.clk(clk), .rst(rst), .cen(cen), .target(tl_q), .bit_out(left_bit));
  jt12_dac_sd1 #(.W(DAC_W)) u_sd_r (.clk(clk), .rst(rst), .cen(cen), .target(tr_q), .bit_out(right_bit));
  assign left_pcm  = pl_q;
  assign right_pcm = pr_q;
  assign pcm_valid = pv_q;
  assign sat_l     = sat_l_q;
  assign sat_r     = sat_r_q;
endmodule

// File: tb/tb_jt12_dac_out.sv
// tb_jt12_dac_out: directed vectors with hand-computed expectations for jt12_dac_out
module tb_jt12_dac_out;
  logic               clk = 1'b0;
  logic               rst, sample_in, cen, sat_clr;
  logic signed [19:0] left_in, right_in;
  logic signed [15:0] left_pcm, right_pcm;
  logic               pcm_valid, left_bit, right_bit, sat_l, sat_r;
  int                 total = 0;
  int                 bad = 0;
  always #5 clk = ~clk;
  jt12_dac_out #(.IN_W(20), .SHIFT(4), .DAC_W(16)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .left_in(left_in), .right_in(right_in),
    .cen(cen), .sat_clr(sat_clr), .left_pcm(left_pcm), .right_pcm(right_pcm),
    .pcm_valid(pcm_valid), .left_bit(left_bit), .right_bit(right_bit), .sat_l(sat_l), .sat_r(sat_r)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int l, input int r, input logic clr, input int el, input int er, input int esl, input int esr);
    left_in = l[19:0];
    right_in = r[19:0];
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    chk("valid_e0", pcm_valid, 0);
    tick();
    chk("valid_e1", pcm_valid, 0);
    sat_clr = clr;
    tick();
    sat_clr = 1'b0;
    chk("valid_e2", pcm_valid, 1);
    chk("left_pcm", left_pcm, el);
    chk("right_pcm", right_pcm, er);
    chk("sat_l", sat_l, esl);
    chk("sat_r", sat_r, esr);
    tick();
    chk("valid_drop", pcm_valid, 0);
  endtask
  initial begin
    int ones_l, ones_r, cnt;
    logic pl, pr;
    rst = 1'b1; cen = 1'b1; sample_in = 1'b0; sat_clr = 1'b0; left_in = '0; right_in = '0;
    repeat (3) tick();
    chk("rst_left_pcm", left_pcm, 0);
    chk("rst_right_pcm", right_pcm, 0);
    chk("rst_valid", pcm_valid, 0);
    chk("rst_flags", {sat_l, sat_r}, 0);
    chk("rst_bits", {left_bit, right_bit}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_left_bit", left_bit, i % 2);
      chk("idle_right_bit", right_bit, i % 2);
    end
    send(8, 7, 1'b0, 1, 0, 0, 0);
    send(-8, -9, 1'b0, 0, -1, 0, 0);
    send(524287, -524288, 1'b0, 32767, -32768, 1, 0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_l_cleared", sat_l, 0);
    send(524287, 0, 1'b1, 32767, 0, 1, 0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_l_cleared2", sat_l, 0);
    send(524287, -524288, 1'b0, 32767, -32768, 1, 0);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      ones_l += int'(left_bit);
      ones_r += int'(right_bit);
    end
    chk("density_l", ones_l, 65535);
    chk("density_r", ones_r, 0);
    left_in = 20'sd48;
    right_in = 20'sd0;
    sample_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 9) sample_in = 1'b0;
      cnt += int'(pcm_valid);
    end
    chk("held_one_valid", cnt, 1);
    chk("held_left_pcm", left_pcm, 3);
    left_in = 20'sd16; right_in = -20'sd16; sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    left_in = 20'sd32; right_in = -20'sd48; sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    chk("pair1_valid", pcm_valid, 1);
    chk("pair1_left", left_pcm, 1);
    chk("pair1_right", right_pcm, -1);
    tick();
    chk("pair_gap", pcm_valid, 0);
    tick();
    chk("pair2_valid", pcm_valid, 1);
    chk("pair2_left", left_pcm, 2);
    chk("pair2_right", right_pcm, -3);
    for (int i = 0; i < 12; i++) begin
      cen = (i % 3 == 2);
      pl = left_bit;
      pr = right_bit;
      tick();
      if (i % 3 != 2) begin
        chk("cen_hold_l", left_bit, pl);
        chk("cen_hold_r", right_bit, pr);
      end
    end
    cen = 1'b1;
    left_in = 20'sd524287; right_in = 20'sd524287; sample_in = 1'b1;
    tick();
    rst = 1'b1;
    sample_in = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_pcm", left_pcm, 0);
    chk("midrst_bits", {left_bit, right_bit}, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(pcm_valid);
      chk("midrst_left_bit", left_bit, i % 2);
    end
    chk("midrst_no_valid", cnt, 0);
    chk("midrst_flags", {sat_l, sat_r}, 0);
    chk("midrst_right_pcm", right_pcm, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
